pen_locator: RTL and testbench
==============================

Name: pen_locator

Overview:
- Converts the debounced light-pen signal into an 8x8 matrix coordinate.
- Sits between the pen debouncer and led_driver.
- led_driver exposes a per-pixel locate scan: scan_row/scan_col plus a strobe when the lit pixel changes. pen_locator times the pen response against that scan.
- Emits a confirmed (row, col) write request; led_driver uses it to set the pixel in its frame RAM.

Parameters:
- SETTLE_CYC, 16: cycles after scan_strobe before sampling starts (phototransistor rise time).
- WIN_CYC, 32: sample window length in cycles.
- THRESH, 24: minimum high samples in the window for a pixel to count as a candidate.
- CONFIRM_FRAMES, 2: consecutive frames with an identical candidate required before a hit is emitted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  locating enabled (drawing state); low forces IDLE
- frame_start  in  1  1-cycle pulse at the start of each locate scan frame
- scan_strobe  in  1  1-cycle pulse when scan advances to a new pixel
- scan_row  in  3  row of the pixel currently lit, valid at scan_strobe
- scan_col  in  3  column of the pixel currently lit, valid at scan_strobe
- pen_in  in  1  debounced pen signal, 1 = light seen
- hit_valid  out  1  1-cycle pulse: confirmed coordinate
- hit_row  out  3  confirmed row, held until next hit
- hit_col  out  3  confirmed column, held until next hit
- busy  out  1  high in SETTLE or SAMPLE

Behaviour:
- Reset: all outputs 0; state IDLE; candidate cleared; confirm count 0; sample count 0.
- Per-pixel FSM, states IDLE, SETTLE, SAMPLE, JUDGE:
  - IDLE -> SETTLE on scan_strobe while en=1. Latch scan_row/scan_col into cur_row/cur_col; load the timer with SETTLE_CYC-1.
  - SETTLE: timer reaches 0 -> SAMPLE. Load the timer with WIN_CYC-1 and clear the sample count.
  - SAMPLE: each cycle, sample count += pen_in (saturating, width clog2(WIN_CYC+1)). Timer reaches 0 -> JUDGE.
  - JUDGE (1 cycle): if count >= THRESH and no frame candidate exists yet, candidate <= cur_row/cur_col and cand_found <= 1. Then -> IDLE.
- Only the first qualifying pixel per frame becomes the candidate; later qualifying pixels are ignored.
- scan_strobe arriving in SETTLE or SAMPLE aborts the current pixel with no judgement. The FSM restarts in SETTLE with the new coordinates on the next cycle.
- scan_strobe in JUDGE: the judgement completes this cycle and the new pixel enters SETTLE next cycle; the strobe is not lost.
- frame_start evaluates the previous frame:
  - If cand_found and the candidate equals last_cand with confirm count > 0: confirm count += 1, saturating at CONFIRM_FRAMES.
  - Else if cand_found: last_cand <= candidate; confirm count <= 1.
  - Else: confirm count <= 0.
  - Then cand_found <= 0 and the FSM aborts to IDLE.
  - frame_start and scan_strobe in the same cycle: the frame evaluation happens first, then the strobe is treated as the first pixel of the new frame.
- hit_valid pulses 1 cycle after the frame_start on which the confirm count first reaches CONFIRM_FRAMES. hit_row/hit_col update in that same cycle.
- Pen held on the same pixel: no further pulses until the confirm count drops below CONFIRM_FRAMES and is re-reached.
- en=0: synchronous return to IDLE. Clears candidate, confirm count, and busy. hit_row/hit_col are retained.
- Asynchronous reset mid-window: immediate clear, no hit emitted.

Optional Feature:
- PEN_INTERP_EN defined: within a frame, up to 2 horizontally adjacent qualifying pixels (same row, col differing by 1) are both recorded. The candidate becomes the one with the higher sample count; on a tie, the lower column wins.
- PEN_INTERP_EN undefined: first-qualifying-pixel rule only, with no second-count storage.

Decomposition:
- Shared package (pen_pkg): FSM state encoding, coordinate width 3, and default SETTLE_CYC/WIN_CYC/THRESH/CONFIRM_FRAMES constants shared with led_driver.
- One natural sub-module, pen_window: the SETTLE/SAMPLE timer and saturating sample counter. It outputs done and count.

Test Plan:
- Pen high for the entire window of pixel (3,5) across 2 frames -> hit_valid pulse 1 cycle after the 3rd frame_start; hit_row=3, hit_col=5.
- Pen high for only 20 of 32 samples (below THRESH=24) -> no candidate and no hit_valid over 4 frames.
- Frame A candidate (2,2), frame B candidate (2,3) -> confirm count restarts at 1 and no hit; frame C (2,3) -> hit (2,3).
- scan_strobe mid-SAMPLE for pixel (1,1) with pen high -> (1,1) not judged; next pixel enters SETTLE the following cycle; busy stays high.
- rst_n asserted mid-SAMPLE -> all outputs 0 asynchronously; no hit after release until 2 fresh confirmed frames.
- PEN_INTERP_EN defined, pixel (4,4) count 26 and (4,5) count 30 in 2 frames -> hit (4,5).

Source files
------------

// File: rtl/pen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pen_pkg                                                    |
// | Description : Shared definitions for the light-pen locator: coordinate   |
// |               width, pixel-timing defaults shared with led_driver, the   |
// |               per-pixel FSM encoding and a coordinate helper.            |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pen_pkg;

   localparam int COORD_W            = 3;

   // Default pixel timing, also used by led_driver to pace its locate scan
   localparam int SETTLE_CYC_DEF     = 16;
   localparam int WIN_CYC_DEF        = 32;
   localparam int THRESH_DEF         = 24;
   localparam int CONFIRM_FRAMES_DEF = 2;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t row;
      coord_t col;
   } pen_xy_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_JUDGE  = 2'd3
   } pen_state_t;

   // Same row, columns differing by exactly one. Columns are widened by a bit
   // so that column 7 is never treated as a neighbour of column 0.
   function automatic logic is_h_adjacent(input pen_xy_t a, input pen_xy_t b);
      logic [COORD_W:0] ac;
      logic [COORD_W:0] bc;
      ac = {1'b0, a.col};
      bc = {1'b0, b.col};
      return (a.row == b.row) && ((ac + 1'b1 == bc) || (bc + 1'b1 == ac));
   endfunction

endpackage
`default_nettype wire

// File: rtl/pen_locator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pen_locator_if                                             |
// | Description : Link between led_driver and pen_locator. led_driver (master)|
// |               drives the locate-scan timing; pen_locator (slave) returns |
// |               the confirmed pixel write request.                         |
// | Signals     : frame_start, scan_strobe, scan_row[2:0], scan_col[2:0]     |
// |               (master->slave); hit_valid, hit_row[2:0], hit_col[2:0]     |
// |               (slave->master)                                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface pen_locator_if;
   import pen_pkg::*;

   logic   frame_start;
   logic   scan_strobe;
   coord_t scan_row;
   coord_t scan_col;
   logic   hit_valid;
   coord_t hit_row;
   coord_t hit_col;

   modport master (
      output frame_start, scan_strobe, scan_row, scan_col,
      input  hit_valid, hit_row, hit_col
   );

   modport slave (
      input  frame_start, scan_strobe, scan_row, scan_col,
      output hit_valid, hit_row, hit_col
   );

endinterface
`default_nettype wire

// File: rtl/pen_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pen_window                                                 |
// | Description : Settle/sample timer and saturating pen sample counter for  |
// |               one pixel. The owner FSM loads the settle or window period,|
// |               keeps run high while settling/sampling, and enables        |
// |               sample only in the sampling phase.                         |
// | Ports       : clk, rst_n (async, active low)                             |
// |               load_settle  load timer with SETTLE_CYC-1                  |
// |               load_win     load timer with WIN_CYC-1, clear count        |
// |               run          timer counts down                             |
// |               sample       accumulate pen_in into count                  |
// |               pen_in       debounced pen signal                          |
// |               done         timer at zero while running                   |
// |               count        high-sample count of the current window       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pen_window #(
   parameter int SETTLE_CYC = 16,
   parameter int WIN_CYC    = 32,
   parameter int CNT_W      = $clog2(WIN_CYC + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_settle,
   input  logic             load_win,
   input  logic             run,
   input  logic             sample,
   input  logic             pen_in,
   output logic             done,
   output logic [CNT_W-1:0] count
);

   localparam int MAX_CYC = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
   localparam int TMR_W   = $clog2(MAX_CYC + 1);

   localparam logic [TMR_W-1:0] c_settle_load = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0] c_win_load    = TMR_W'(WIN_CYC - 1);
   localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};

   logic [TMR_W-1:0] r_timer;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
         r_count <= '0;
      end else if (load_settle) begin
         r_timer <= c_settle_load;
      end else if (load_win) begin
         r_timer <= c_win_load;
         r_count <= '0;
      end else if (run) begin
         if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
         end
         if (sample && pen_in && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign done  = run && (r_timer == '0);
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pen_locator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pen_locator                                                |
// | Description : Times the debounced light-pen response against the        |
// |               led_driver locate scan. Each lit pixel is settled, sampled |
// |               and judged; the first qualifying pixel of a frame becomes  |
// |               the frame candidate, and a candidate repeated over         |
// |               CONFIRM_FRAMES consecutive frames is emitted once as a hit.|
// | Ports       : clk, rst_n (async, active low), en (locating enabled),     |
// |               pen_in (debounced pen), busy (settling or sampling),       |
// |               bus (pen_locator_if.slave: scan timing in, hit out)        |
// | Options     : PEN_INTERP_EN - record up to two horizontally adjacent     |
// |               qualifying pixels per frame and keep the stronger one      |
// |               (tie: lower column).                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pen_locator
   import pen_pkg::*;
#(
   parameter int SETTLE_CYC     = SETTLE_CYC_DEF,
   parameter int WIN_CYC        = WIN_CYC_DEF,
   parameter int THRESH         = THRESH_DEF,
   parameter int CONFIRM_FRAMES = CONFIRM_FRAMES_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         pen_in,
   output logic         busy,
   pen_locator_if.slave bus
);

   localparam int CNT_W  = $clog2(WIN_CYC + 1);
   localparam int CONF_W = $clog2(CONFIRM_FRAMES + 1);

   localparam logic [CNT_W-1:0]  c_thresh      = CNT_W'(THRESH);
   localparam logic [CONF_W-1:0] c_confirm_max = CONF_W'(CONFIRM_FRAMES);

   pen_state_t        r_state;
   pen_state_t        w_state_nxt;
   logic              w_load_settle;
   logic              w_load_win;
   logic              w_judge;
   logic              w_win_run;
   logic              w_win_sample;
   logic              w_win_done;
   logic [CNT_W-1:0]  w_win_count;

   pen_xy_t           w_scan_xy;
   pen_xy_t           r_cur;
   pen_xy_t           r_cand;
   pen_xy_t           r_last;
   pen_xy_t           r_hit;
   logic              r_cand_found;
   logic [CONF_W-1:0] r_confirm;
   logic [CONF_W-1:0] w_confirm_nxt;
   logic              w_same_cand;
   logic              w_hit_now;
   logic              w_qualify;
   logic              w_take_cand;
   logic              r_hit_valid;

   assign w_scan_xy    = '{row: bus.scan_row, col: bus.scan_col};
   assign w_win_run    = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
   assign w_win_sample = (r_state == ST_SAMPLE);
   assign busy         = w_win_run;

   pen_window #(
      .SETTLE_CYC (SETTLE_CYC),
      .WIN_CYC    (WIN_CYC),
      .CNT_W      (CNT_W)
   ) u_window (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_settle (w_load_settle),
      .load_win    (w_load_win),
      .run         (w_win_run),
      .sample      (w_win_sample),
      .pen_in      (pen_in),
      .done        (w_win_done),
      .count       (w_win_count)
   );

   // ---------------------------------------------------------------------
   // Per-pixel FSM. A strobe always starts a fresh pixel: from IDLE it is a
   // normal start, in SETTLE/SAMPLE it discards the pixel unjudged, and in
   // JUDGE the judgement still completes in the same cycle. frame_start
   // drops any pixel in flight; a coincident strobe opens the new frame.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_load_settle = 1'b0;
      w_load_win    = 1'b0;
      w_judge       = 1'b0;
      if (!en) begin
         w_state_nxt = ST_IDLE;
      end else if (bus.frame_start) begin
         if (bus.scan_strobe) begin
            w_state_nxt   = ST_SETTLE;
            w_load_settle = 1'b1;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end else if (bus.scan_strobe) begin
         w_state_nxt   = ST_SETTLE;
         w_load_settle = 1'b1;
         w_judge       = (r_state == ST_JUDGE);
      end else begin
         case (r_state)
            ST_SETTLE: begin
               if (w_win_done) begin
                  w_state_nxt = ST_SAMPLE;
                  w_load_win  = 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (w_win_done) begin
                  w_state_nxt = ST_JUDGE;
               end
            end
            ST_JUDGE: begin
               w_judge     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cur   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_settle) begin
            r_cur <= w_scan_xy;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Candidate selection
   // ---------------------------------------------------------------------
   assign w_qualify = w_judge && (w_win_count >= c_thresh);

`ifdef PEN_INTERP_EN
   // Count of the current candidate and whether its neighbour slot is used
   logic [CNT_W-1:0] r_cand_cnt;
   logic             r_second_used;
   logic             w_adjacent;
   logic             w_better;

   assign w_adjacent  = is_h_adjacent(r_cand, r_cur);
   assign w_better    = (w_win_count > r_cand_cnt) ||
                        ((w_win_count == r_cand_cnt) && (r_cur.col < r_cand.col));
   assign w_take_cand = w_qualify &&
                        (!r_cand_found || (!r_second_used && w_adjacent && w_better));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand_cnt    <= '0;
         r_second_used <= 1'b0;
      end else if (!en || bus.frame_start) begin
         r_cand_cnt    <= '0;
         r_second_used <= 1'b0;
      end else if (w_qualify) begin
         if (!r_cand_found) begin
            r_cand_cnt    <= w_win_count;
            r_second_used <= 1'b0;
         end else if (!r_second_used && w_adjacent) begin
            r_second_used <= 1'b1;
            if (w_better) begin
               r_cand_cnt <= w_win_count;
            end
         end
      end
   end
`else
   assign w_take_cand = w_qualify && !r_cand_found;
`endif

   // ---------------------------------------------------------------------
   // Frame evaluation. The confirm count only keeps climbing while the same
   // candidate reappears in back-to-back frames; a hit fires on the frame
   // where the count newly arrives at CONFIRM_FRAMES, not while it sits
   // saturated there.
   // ---------------------------------------------------------------------
   assign w_same_cand = r_cand_found && (r_cand == r_last) && (r_confirm != '0);

   always_comb begin
      w_confirm_nxt = '0;
      if (w_same_cand) begin
         w_confirm_nxt = (r_confirm == c_confirm_max) ? r_confirm : r_confirm + 1'b1;
      end else if (r_cand_found) begin
         w_confirm_nxt = CONF_W'(1);
      end
   end

   assign w_hit_now = (w_confirm_nxt == c_confirm_max) &&
                      !(w_same_cand && (r_confirm == c_confirm_max));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand       <= '0;
         r_cand_found <= 1'b0;
         r_last       <= '0;
         r_confirm    <= '0;
         r_hit_valid  <= 1'b0;
         r_hit        <= '0;
      end else if (!en) begin
         r_cand       <= '0;
         r_cand_found <= 1'b0;
         r_last       <= '0;
         r_confirm    <= '0;
         r_hit_valid  <= 1'b0;
      end else if (bus.frame_start) begin
         r_cand_found <= 1'b0;
         r_confirm    <= w_confirm_nxt;
         r_hit_valid  <= w_hit_now;
         if (r_cand_found && !w_same_cand) begin
            r_last <= r_cand;
         end
         if (w_hit_now) begin
            r_hit <= r_cand;
         end
      end else begin
         r_hit_valid <= 1'b0;
         if (w_take_cand) begin
            r_cand       <= r_cur;
            r_cand_found <= 1'b1;
         end
      end
   end

   assign bus.hit_valid = r_hit_valid;
   assign bus.hit_row   = r_hit.row;
   assign bus.hit_col   = r_hit.col;

endmodule
`default_nettype wire

// File: tb/tb_pen_locator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pen_locator                                             |
// | Description : Directed self-checking bench for pen_locator. Drives the   |
// |               locate scan pixel by pixel (strobe, 16 settle cycles, 32   |
// |               sample cycles, 1 judge cycle) and checks hits at each      |
// |               frame boundary against hand-computed values.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pen_locator;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic pen_in;
   logic busy;

   int   n_checks = 0;
   int   n_errors = 0;

   pen_locator_if bus ();

   pen_locator dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .pen_in (pen_in),
      .busy   (busy),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One full pixel: strobe, settle, 32-cycle window with pen high for the
   // first nhigh samples, then the judge cycle.
   task automatic run_pixel(input int r, input int c, input int nhigh);
      bus.scan_strobe = 1'b1;
      bus.scan_row    = 3'(r);
      bus.scan_col    = 3'(c);
      tick();
      bus.scan_strobe = 1'b0;
      check_val("busy_settle", 32'(busy), 32'd1);
      repeat (16) tick();
      for (int i = 0; i < 32; i++) begin
         pen_in = (i < nhigh);
         tick();
      end
      pen_in = 1'b0;
      tick();
   endtask

   task automatic end_frame(input string tag, input logic exp_hit, input int r, input int c);
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      check_val({tag, "_hv"}, 32'(bus.hit_valid), 32'(exp_hit));
      if (exp_hit) begin
         check_val({tag, "_row"}, 32'(bus.hit_row), 32'(r));
         check_val({tag, "_col"}, 32'(bus.hit_col), 32'(c));
      end
      tick();
      check_val({tag, "_hv_pulse"}, 32'(bus.hit_valid), 32'd0);
   endtask

   initial begin
      rst_n           = 1'b0;
      en              = 1'b0;
      pen_in          = 1'b0;
      bus.frame_start = 1'b0;
      bus.scan_strobe = 1'b0;
      bus.scan_row    = '0;
      bus.scan_col    = '0;
      repeat (3) tick();
      check_val("rst_hv",   32'(bus.hit_valid), 32'd0);
      check_val("rst_row",  32'(bus.hit_row),   32'd0);
      check_val("rst_col",  32'(bus.hit_col),   32'd0);
      check_val("rst_busy", 32'(busy),          32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      tick();

      // Full window on (3,5) in two frames -> hit on third frame_start
      end_frame("t1_f0", 1'b0, 0, 0);
      run_pixel(3, 5, 32);
      run_pixel(0, 1, 0);
      end_frame("t1_f1", 1'b0, 0, 0);
      run_pixel(3, 5, 32);
      end_frame("t1_f2", 1'b1, 3, 5);
      // Pen held: confirm count saturated, no repeat pulse
      run_pixel(3, 5, 32);
      end_frame("t1_hold", 1'b0, 0, 0);
      check_val("t1_hold_row", 32'(bus.hit_row), 32'd3);

      // 20 of 32 samples: below threshold, never a candidate
      for (int f = 0; f < 4; f++) begin
         run_pixel(6, 6, 20);
         end_frame("t2_low", 1'b0, 0, 0);
      end
      // Exactly THRESH samples qualifies
      run_pixel(7, 0, 24);
      end_frame("t2_th1", 1'b0, 0, 0);
      run_pixel(7, 0, 24);
      end_frame("t2_th2", 1'b1, 7, 0);

      // Candidate change restarts confirmation
      run_pixel(2, 2, 32);
      end_frame("t3_a", 1'b0, 0, 0);
      run_pixel(2, 3, 32);
      end_frame("t3_b", 1'b0, 0, 0);
      run_pixel(2, 3, 32);
      end_frame("t3_c", 1'b1, 2, 3);

      // First qualifying pixel of a frame wins
      for (int f = 0; f < 2; f++) begin
         run_pixel(6, 1, 32);
         run_pixel(6, 7, 32);
         end_frame("t4_first", f == 1, 6, 1);
      end

      // Strobe mid-SAMPLE aborts (1,1); (2,6) restarts immediately
      for (int f = 0; f < 2; f++) begin
         pen_in          = 1'b1;
         bus.scan_strobe = 1'b1;
         bus.scan_row    = 3'd1;
         bus.scan_col    = 3'd1;
         tick();
         bus.scan_strobe = 1'b0;
         repeat (26) tick();
         check_val("t5_busy_pre", 32'(busy), 32'd1);
         bus.scan_strobe = 1'b1;
         bus.scan_row    = 3'd2;
         bus.scan_col    = 3'd6;
         tick();
         bus.scan_strobe = 1'b0;
         check_val("t5_busy_post", 32'(busy), 32'd1);
         repeat (48) tick();
         pen_in = 1'b0;
         tick();
         end_frame("t5_abort", f == 1, 2, 6);
      end

      // en low mid-pixel: busy drops, confirmation cleared, hit retained
      run_pixel(5, 2, 32);
      end_frame("t6_f1", 1'b0, 0, 0);
      bus.scan_strobe = 1'b1;
      bus.scan_row    = 3'd5;
      bus.scan_col    = 3'd2;
      tick();
      bus.scan_strobe = 1'b0;
      pen_in          = 1'b1;
      repeat (20) tick();
      en = 1'b0;
      tick();
      check_val("t6_busy_off", 32'(busy),         32'd0);
      check_val("t6_row_keep", 32'(bus.hit_row),  32'd2);
      check_val("t6_col_keep", 32'(bus.hit_col),  32'd6);
      pen_in = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      tick();
      run_pixel(5, 2, 32);
      end_frame("t6_f2", 1'b0, 0, 0);
      run_pixel(5, 2, 32);
      end_frame("t6_f3", 1'b1, 5, 2);

      // Asynchronous reset mid-SAMPLE
      run_pixel(3, 5, 32);
      end_frame("t7_pre", 1'b0, 0, 0);
      bus.scan_strobe = 1'b1;
      bus.scan_row    = 3'd3;
      bus.scan_col    = 3'd5;
      tick();
      bus.scan_strobe = 1'b0;
      pen_in          = 1'b1;
      repeat (26) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t7_row", 32'(bus.hit_row),   32'd0);
      check_val("t7_col", 32'(bus.hit_col),   32'd0);
      check_val("t7_hv",  32'(bus.hit_valid), 32'd0);
      check_val("t7_busy", 32'(busy),         32'd0);
      pen_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_pixel(3, 5, 32);
      end_frame("t7_f1", 1'b0, 0, 0);
      run_pixel(3, 5, 32);
      end_frame("t7_f2", 1'b1, 3, 5);

      // Adjacent pair (4,4)=26, (4,5)=30
      for (int f = 0; f < 2; f++) begin
         run_pixel(4, 4, 26);
         run_pixel(4, 5, 30);
`ifdef PEN_INTERP_EN
         end_frame("t8_interp", f == 1, 4, 5);
`else
         end_frame("t8_interp", f == 1, 4, 4);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
